// File: rtl/cpu6502_pkg.sv
// Shared 6502 definitions: status-register bit positions and the power-on P value.
package cpu6502_pkg;

  localparam int P_C = 0;
  localparam int P_Z = 1;
  localparam int P_I = 2;
  localparam int P_D = 3;
  localparam int P_B = 4;
  localparam int P_U = 5;
  localparam int P_V = 6;
  localparam int P_N = 7;

  localparam logic [7:0] RESET_P_DEFAULT = 8'h24;

endpackage

// File: rtl/so_edge_detector.sv
// Flags a falling edge on the already-synchronous SO pin, combinationally in the cycle of the fall.
// History resets high so a pin held low through reset release never reads as an edge.
module so_edge_detector (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_so,
  output logic o_so_fall
);

  logic so_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) so_q <= 1'b1;
    else            so_q <= i_so;
  end

  assign o_so_fall = so_q & ~i_so;

endmodule

// File: rtl/processor_status_register.sv
// 6502 P register: per-flag prioritised loads from ALU, data bus and IR5; flags visible one cycle after strobe.
// Only o_p_db bit 4 (B, from i_brk) is combinational; there is no backpressure.
import cpu6502_pkg::*;

module processor_status_register #(
  parameter logic [7:0] RESET_P = cpu6502_pkg::RESET_P_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [7:0] i_db,
  input  logic       i_ir5,
  input  logic       i_acr,
  input  logic       i_avr,
  input  logic       i_db0_c,
  input  logic       i_ir5_c,
  input  logic       i_acr_c,
  input  logic       i_db1_z,
  input  logic       i_dbz_z,
  input  logic       i_db2_i,
  input  logic       i_ir5_i,
  input  logic       i_1_i,
  input  logic       i_db3_d,
  input  logic       i_ir5_d,
  input  logic       i_db6_v,
  input  logic       i_avr_v,
  input  logic       i_0_v,
  input  logic       i_db7_n,
  input  logic       i_so,
  input  logic       i_brk,
  output logic [7:0] o_p,
  output logic [7:0] o_p_db,
  output logic       o_c,
  output logic       o_z,
  output logic       o_i,
  output logic       o_d,
  output logic       o_v,
  output logic       o_n
);

  logic c_q, z_q, i_q, d_q, v_q, n_q;
  logic c_d, z_d, i_d, d_d, v_d, n_d;
  logic so_fall;

  so_edge_detector u_so_edge (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_so      (i_so),
    .o_so_fall (so_fall)
  );

  // Each flag picks its highest-priority active source, otherwise holds.
  always_comb begin
    c_d = c_q;
    if (i_acr_c)      c_d = i_acr;
    else if (i_db0_c) c_d = i_db[P_C];
    else if (i_ir5_c) c_d = i_ir5;

    z_d = z_q;
    if (i_dbz_z)      z_d = ~|i_db;
    else if (i_db1_z) z_d = i_db[P_Z];

    i_d = i_q;
    if (i_1_i)        i_d = 1'b1;
    else if (i_db2_i) i_d = i_db[P_I];
    else if (i_ir5_i) i_d = i_ir5;

    d_d = d_q;
    if (i_db3_d)      d_d = i_db[P_D];
    else if (i_ir5_d) d_d = i_ir5;

    v_d = v_q;
    if (so_fall)      v_d = 1'b1;
    else if (i_avr_v) v_d = i_avr;
    else if (i_db6_v) v_d = i_db[P_V];
    else if (i_0_v)   v_d = 1'b0;

    n_d = n_q;
    if (i_db7_n)      n_d = i_db[P_N];
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      c_q <= RESET_P[P_C];
      z_q <= RESET_P[P_Z];
      i_q <= RESET_P[P_I];
      d_q <= RESET_P[P_D];
      v_q <= RESET_P[P_V];
      n_q <= RESET_P[P_N];
    end else begin
      c_q <= c_d;
      z_q <= z_d;
      i_q <= i_d;
      d_q <= d_d;
      v_q <= v_d;
      n_q <= n_d;
    end
  end

  // B is never stored: it reads 1 in o_p and reflects the push source in o_p_db.
  assign o_p    = {n_q, v_q, 1'b1, 1'b1,  d_q, i_q, z_q, c_q};
  assign o_p_db = {n_q, v_q, 1'b1, i_brk, d_q, i_q, z_q, c_q};

  assign o_c = c_q;
  assign o_z = z_q;
  assign o_i = i_q;
  assign o_d = d_q;
  assign o_v = v_q;
  assign o_n = n_q;

endmodule

// File: doc/processor_status_register.md
Name: processor_status_register

Overview:
- Holds the 6502 processor status flags N, V, -, B, D, I, Z, C. Sits directly downstream of the ALU.
- Captures the ALU carry/overflow signals (ACR/AVR) and the data-bus result under per-flag load controls from the timing/decode logic.
- Drives the packed P byte back onto the data bus for PHP/BRK/IRQ/NMI pushes.
- Detects falling edges on the SO (set-overflow) pin.

Parameters:
- RESET_P, 8'h24, P value after reset: I=1 and bit5=1, all other flags 0.

Ports:
- i_clk  input  1  system clock; all state updates on rising edge
- i_reset_n  input  1  asynchronous active-low reset
- i_db  input  8  internal data bus
- i_ir5  input  1  instruction register bit 5; value for SEC/CLC, SEI/CLI, SED/CLD
- i_acr  input  1  ALU carry out
- i_avr  input  1  ALU overflow out
- i_db0_c  input  1  load C from i_db[0]
- i_ir5_c  input  1  load C from i_ir5
- i_acr_c  input  1  load C from i_acr
- i_db1_z  input  1  load Z from i_db[1]
- i_dbz_z  input  1  load Z with (i_db == 8'h00)
- i_db2_i  input  1  load I from i_db[2]
- i_ir5_i  input  1  load I from i_ir5
- i_1_i  input  1  set I (interrupt sequence)
- i_db3_d  input  1  load D from i_db[3]
- i_ir5_d  input  1  load D from i_ir5
- i_db6_v  input  1  load V from i_db[6]
- i_avr_v  input  1  load V from i_avr
- i_0_v  input  1  clear V (CLV)
- i_db7_n  input  1  load N from i_db[7]
- i_so  input  1  set-overflow pin, already synchronous to i_clk
- i_brk  input  1  B value presented on o_p_db during push (1 = PHP/BRK, 0 = IRQ/NMI)
- o_p  output  8  current status {N,V,1,1,D,I,Z,C}
- o_p_db  output  8  push value {N,V,1,i_brk,D,I,Z,C}
- o_c, o_z, o_i, o_d, o_v, o_n  output  1 each  individual flag outputs

Behaviour:
- Reset (asynchronous, i_reset_n=0):
  - Flags take RESET_P: C=0, Z=0, I=1, D=0, V=0, N=0.
  - The SO history register resets to 1, so a low SO pin at reset release is not treated as an edge.
  - o_p = 8'h34 and o_p_db = {8'h24 | i_brk<<4}.
  - Reset asserted mid-update overrides any load.
- Flag storage: flags are registers updated on the rising edge of i_clk. Outputs follow one cycle after the control strobe (no combinational path from controls to o_p). o_p_db bit4 is the only combinational term (from i_brk).
- Flag priorities when several load controls for the same flag are asserted together (highest first):
  - C: i_acr_c > i_db0_c > i_ir5_c
  - Z: i_dbz_z > i_db1_z
  - I: i_1_i > i_db2_i > i_ir5_i
  - D: i_db3_d > i_ir5_d
  - V: SO falling edge > i_avr_v > i_db6_v > i_0_v
  - N: single source, i_db7_n
- Independence: loads to different flags in the same cycle are independent (e.g. ADC: i_acr_c, i_avr_v, i_dbz_z and i_db7_n all in one cycle).
- No strobe: a flag with no strobe holds its value.
- SO edge detection:
  - so_q <= i_so every cycle.
  - An edge is detected when so_q=1 and i_so=0; V is set on that same clock edge.
  - i_so held low produces only one set. Rising edges are ignored.
  - An edge coincident with i_0_v sets V (SO wins).
- Z from bus: i_dbz_z computes Z = ~|i_db, evaluated on the cycle of the strobe.
- Fixed bits: bit5 always reads 1. Bit4 of o_p always reads 1; B is not stored.
- PLP/RTI: all of i_db0_c, i_db1_z, i_db2_i, i_db3_d, i_db6_v and i_db7_n are asserted in one cycle. Bits 4 and 5 of i_db are discarded.

Decomposition:
- Shared package cpu6502_pkg:
  - Flag bit indices P_C=0, P_Z=1, P_I=2, P_D=3, P_B=4, P_U=5, P_V=6, P_N=7
  - RESET_P default value
- Sub-module so_edge_detector:
  - Ports: i_clk, i_reset_n, i_so, o_so_fall
  - Contains the so_q register (resets to 1).

Test Plan:
- Reset release with all strobes low -> o_p=8'h34, o_i=1; hold 5 cycles, o_p unchanged.
- i_acr=1, i_avr=1, i_db=8'h80 with i_acr_c, i_avr_v, i_dbz_z, i_db7_n for one cycle -> next cycle C=1, V=1, Z=0, N=1, o_p=8'hF5.
- PLP: i_db=8'hCB with all db*_ strobes -> o_p=8'hFB (N,V,D,Z,C set; I=0); with i_brk=0, o_p_db=8'hEB.
- i_acr_c and i_db0_c together, i_acr=0, i_db[0]=1 -> C=0. Then i_1_i and i_ir5_i together with i_ir5=0 -> I=1.
- i_so 1->0 held low 4 cycles -> V=1 after first edge. Then i_0_v -> V=0 and stays 0 while i_so remains low. Then i_so falls again coincident with i_0_v -> V=1.
- Assert i_reset_n low asynchronously mid-cycle while i_db7_n is active -> o_p=8'h34 immediately, without waiting for a clock edge.
